// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - state encodings and memory-class codes for cpu_sequencer
// Purpose: shared FSM state type, decoder mem_control codes and a class helper.
// Ports: none (package).
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd7
    } seq_state_t;

    localparam logic [2:0] MEMC_NONE  = 3'b000;
    localparam logic [2:0] MEMC_STORE = 3'b101;
    localparam logic [2:0] MEMC_LOAD  = 3'b110;

    // Only the two legal memory codes take the MEM path; every other code,
    // including illegal ones, is executed as an ALU/branch instruction.
    function automatic logic is_mem_access(input logic [2:0] memc);
        return (memc == MEMC_LOAD) || (memc == MEMC_STORE);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - decoder/memory/datapath control bundle for cpu_sequencer
// Purpose: groups the sequencer's decoder inputs, memory handshake and datapath controls.
// Signals: dec_mem_control/dec_write_reg/dec_branch (decoder), mem_ack/mem_req/mem_we/
//   mem_addr_sel (memory port), ir_load/pc_en/pc_sel_branch/rf_we/wb_sel_mem (datapath),
//   fault/state (status). With CPU_SEQ_SINGLE_STEP_EN: step (in), halted (out).
// Modports: master = sequencer side, slave = datapath/memory side.
interface cpu_sequencer_if;
    logic [2:0] dec_mem_control;
    logic       dec_write_reg;
    logic       dec_branch;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_en;
    logic       pc_sel_branch;
    logic       rf_we;
    logic       wb_sel_mem;
    logic       fault;
    logic [2:0] state;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic       step;
    logic       halted;
`endif

    modport master (
        input  dec_mem_control, dec_write_reg, dec_branch, mem_ack,
`ifdef CPU_SEQ_SINGLE_STEP_EN
        input  step,
        output halted,
`endif
        output mem_req, mem_we, mem_addr_sel, ir_load, pc_en, pc_sel_branch,
        output rf_we, wb_sel_mem, fault, state
    );

    modport slave (
        output dec_mem_control, dec_write_reg, dec_branch, mem_ack,
`ifdef CPU_SEQ_SINGLE_STEP_EN
        output step,
        input  halted,
`endif
        input  mem_req, mem_we, mem_addr_sel, ir_load, pc_en, pc_sel_branch,
        input  rf_we, wb_sel_mem, fault, state
    );
endinterface

// File: rtl/cpu_sequencer_timeout.sv
// rtl/cpu_sequencer_timeout.sv - memory-stall watchdog counter for cpu_sequencer
// Purpose: counts stalled request cycles; flags expiry on the cycle the count reaches MEM_TIMEOUT.
// Ports: clk, reset (sync, active-high), i_clear, i_inc, o_expired.
module seq_timeout_counter #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LP_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // The stalled cycle that would bring the count to MEM_TIMEOUT is the
    // expiring one; i_inc already excludes mem_ack, so an ack there wins.
    assign o_expired = i_inc && (r_cnt == LP_LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle fetch/decode/exec/mem/wb control FSM
// Purpose: sequences the 16-bit CPU datapath and arbitrates its single memory port.
// Ports: clk, reset (sync, active-high), bus (cpu_sequencer_if.master).
// Params: MEM_TIMEOUT (1..255 stalled cycles before fault), TO_W (counter width).
// Option: CPU_SEQ_SINGLE_STEP_EN adds HALT state with step input / halted output.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_sequencer_if.master        bus
);
    import cpu_sequencer_pkg::*;

    seq_state_t r_state;
    seq_state_t w_next;
    seq_state_t w_done_state;

    logic w_mem_req;
    logic w_mem_we;
    logic w_mem_addr_sel;
    logic w_ir_load;
    logic w_pc_en;
    logic w_pc_sel_branch;
    logic w_rf_we;
    logic w_wb_sel_mem;
    logic w_fault;
    logic w_halted;
    logic w_to_clear;
    logic w_to_inc;
    logic w_to_expired;
    logic w_step_rise;

`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic r_step_d1;
    logic r_step_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_d1 <= 1'b0;
            r_step_d2 <= 1'b0;
        end else begin
            r_step_d1 <= bus.step;
            r_step_d2 <= r_step_d1;
        end
    end

    assign w_step_rise  = r_step_d1 & ~r_step_d2;
    assign w_done_state = ST_HALT;
`else
    assign w_step_rise  = 1'b0;
    assign w_done_state = ST_FETCH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Stall counting is derived straight from state so the watchdog path
    // does not loop back through the next-state logic.
    assign w_to_inc   = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !bus.mem_ack;
    assign w_to_clear = bus.mem_ack || (w_next != r_state);

    seq_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_to_clear),
        .i_inc     (w_to_inc),
        .o_expired (w_to_expired)
    );

    always_comb begin
        w_next          = r_state;
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_addr_sel  = 1'b0;
        w_ir_load       = 1'b0;
        w_pc_en         = 1'b0;
        w_pc_sel_branch = 1'b0;
        w_rf_we         = 1'b0;
        w_wb_sel_mem    = 1'b0;
        w_fault         = 1'b0;
        w_halted        = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_load = 1'b1;
                    w_next    = ST_DECODE;
                end else if (w_to_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem_access(bus.dec_mem_control)) begin
                    w_next = ST_MEM;
                end else begin
                    w_rf_we         = bus.dec_write_reg;
                    w_pc_en         = 1'b1;
                    w_pc_sel_branch = bus.dec_branch;
                    w_next          = w_done_state;
                end
            end
            ST_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (bus.dec_mem_control == MEMC_STORE);
                if (bus.mem_ack) begin
                    if (bus.dec_mem_control == MEMC_STORE) begin
                        w_pc_en = 1'b1;
                        w_next  = w_done_state;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_to_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_WB: begin
                w_rf_we      = 1'b1;
                w_wb_sel_mem = 1'b1;
                w_pc_en      = 1'b1;
                w_next       = w_done_state;
            end
`ifdef CPU_SEQ_SINGLE_STEP_EN
            ST_HALT: begin
                w_halted = 1'b1;
                if (w_step_rise) begin
                    w_next = ST_FETCH;
                end
            end
`endif
            ST_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Outputs are forced low for the whole reset cycle, even though the
    // state register only returns to FETCH on the reset edge.
    assign bus.mem_req       = w_mem_req       & ~reset;
    assign bus.mem_we        = w_mem_we        & ~reset;
    assign bus.mem_addr_sel  = w_mem_addr_sel  & ~reset;
    assign bus.ir_load       = w_ir_load       & ~reset;
    assign bus.pc_en         = w_pc_en         & ~reset;
    assign bus.pc_sel_branch = w_pc_sel_branch & ~reset;
    assign bus.rf_we         = w_rf_we         & ~reset;
    assign bus.wb_sel_mem    = w_wb_sel_mem    & ~reset;
    assign bus.fault         = w_fault         & ~reset;
    assign bus.state         = reset ? 3'd0 : r_state;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign bus.halted        = w_halted        & ~reset;
`endif

    logic w_unused;
    assign w_unused = w_halted ^ w_step_rise;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int TMO = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {bus.state, bus.fault, bus.mem_req, bus.mem_we, bus.mem_addr_sel,
                  bus.ir_load, bus.pc_en, bus.pc_sel_branch, bus.rf_we, bus.wb_sel_mem};

    // Expected output vector: {state, fault, req, we, addr_sel, ir_load, pc_en, pc_sel, rf_we, wb_sel}
    function automatic logic [11:0] ev(input logic [2:0] st, input bit flt, input bit req,
                                       input bit we, input bit asel, input bit irl,
                                       input bit pce, input bit pcs, input bit rfw, input bit wbs);
        return {st, flt, req, we, asel, irl, pce, pcs, rfw, wbs};
    endfunction

    task automatic chk(input string tag, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
`ifdef CPU_SEQ_SINGLE_STEP_EN
        n_tests++;
        assert (bus.halted === (exp[11:9] == 3'd5)) else begin
            n_fail++;
            $error("FAIL %s_halted observed=%b expected=%b", tag, bus.halted, exp[11:9] == 3'd5);
        end
`endif
    endtask

    // One clock cycle: drive ack, check outputs at negedge, advance to just after posedge.
    task automatic cyc(input bit ack, input string tag, input logic [11:0] exp);
        bus.mem_ack = ack;
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fault_then_reset(input string tag);
        for (int i = 0; i < 3; i++) cyc(1'($urandom_range(0, 1)), {tag, "_fault"}, ev(3'd7,1,0,0,0,0,0,0,0,0));
        reset = 1'b1;
        cyc(1'b0, {tag, "_rst"}, '0);
        reset = 1'b0;
    endtask

    task automatic halt_step(input string tag);
`ifdef CPU_SEQ_SINGLE_STEP_EN
        cyc(1'($urandom_range(0, 1)), {tag, "_halt0"}, ev(3'd5,0,0,0,0,0,0,0,0,0));
        bus.step = 1'b1;
        cyc(1'($urandom_range(0, 1)), {tag, "_halt1"}, ev(3'd5,0,0,0,0,0,0,0,0,0));
        bus.step = 1'b0;
        cyc(1'($urandom_range(0, 1)), {tag, "_halt2"}, ev(3'd5,0,0,0,0,0,0,0,0,0));
`endif
    endtask

    // Reference model: expected per-cycle behaviour of one instruction, built from
    // the phase rules (fetch waits, decode, exec, memory waits, writeback), with the
    // watchdog modelled as "fault after TMO consecutive unacknowledged request cycles".
    task automatic run_instr(input string tag, input logic [2:0] memc, input bit wr,
                             input bit br, input int wf, input int wm);
        bit is_mem;
        bit is_st;
        is_mem = (memc == 3'b110) || (memc == 3'b101);
        is_st  = (memc == 3'b101);
        bus.dec_mem_control = memc;
        bus.dec_write_reg   = wr;
        bus.dec_branch      = br;
        for (int i = 0; i < ((wf >= TMO) ? TMO : wf); i++)
            cyc(1'b0, {tag, "_fstall"}, ev(3'd0,0,1,0,0,0,0,0,0,0));
        if (wf >= TMO) begin
            fault_then_reset(tag);
            return;
        end
        cyc(1'b1, {tag, "_fetch"}, ev(3'd0,0,1,0,0,1,0,0,0,0));
        cyc(1'($urandom_range(0, 1)), {tag, "_decode"}, ev(3'd1,0,0,0,0,0,0,0,0,0));
        if (!is_mem) begin
            cyc(1'($urandom_range(0, 1)), {tag, "_exec"}, ev(3'd2,0,0,0,0,0,1,br,wr,0));
            halt_step(tag);
            return;
        end
        cyc(1'($urandom_range(0, 1)), {tag, "_exec"}, ev(3'd2,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < ((wm >= TMO) ? TMO : wm); i++)
            cyc(1'b0, {tag, "_mstall"}, ev(3'd3,0,1,is_st,1,0,0,0,0,0));
        if (wm >= TMO) begin
            fault_then_reset(tag);
            return;
        end
        cyc(1'b1, {tag, "_mem"}, ev(3'd3,0,1,is_st,1,0,is_st,0,0,0));
        if (!is_st)
            cyc(1'($urandom_range(0, 1)), {tag, "_wb"}, ev(3'd4,0,0,0,0,0,1,0,1,1));
        halt_step(tag);
    endtask

    initial begin
        logic [2:0] memc;
        int         wf;
        int         wm;
        bus.mem_ack         = 1'b0;
        bus.dec_mem_control = 3'b000;
        bus.dec_write_reg   = 1'b0;
        bus.dec_branch      = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        bus.step            = 1'b0;
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, "reset_outputs", '0);
        reset = 1'b0;

        run_instr("alu",       3'b000, 1, 0, 0, 0);
        run_instr("branch",    3'b000, 0, 1, 0, 0);
        run_instr("load_w2",   3'b110, 1, 0, 0, 2);
        run_instr("store",     3'b101, 0, 0, 0, 0);
        run_instr("illegal",   3'b011, 1, 1, 1, 0);
        run_instr("fetch_w14", 3'b000, 1, 0, TMO - 1, 0);
        run_instr("load_w14",  3'b110, 1, 0, 0, TMO - 1);
        run_instr("fetch_to",  3'b000, 1, 0, TMO, 0);
        run_instr("after_to",  3'b000, 0, 1, 0, 0);
        run_instr("store_to",  3'b101, 0, 0, 0, TMO);
        run_instr("load_ok",   3'b110, 0, 0, 0, 0);

        // Reset while a load is waiting in MEM with an ack arriving alongside reset.
        bus.dec_mem_control = 3'b110;
        cyc(1'b1, "rmem_fetch", ev(3'd0,0,1,0,0,1,0,0,0,0));
        cyc(1'b0, "rmem_decode", ev(3'd1,0,0,0,0,0,0,0,0,0));
        cyc(1'b0, "rmem_exec", ev(3'd2,0,0,0,0,0,0,0,0,0));
        cyc(1'b0, "rmem_mem", ev(3'd3,0,1,0,1,0,0,0,0,0));
        reset = 1'b1;
        cyc(1'b1, "rmem_gated", '0);
        cyc(1'b1, "rmem_held", '0);
        reset = 1'b0;
        run_instr("after_rmem", 3'b000, 1, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       memc = 3'b000;
                1:       memc = 3'b101;
                2:       memc = 3'b110;
                default: memc = 3'($urandom_range(0, 7));
            endcase
            wf = ($urandom_range(0, 19) == 0) ? TMO : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 19) == 0) ? TMO : int'($urandom_range(0, 3));
            run_instr($sformatf("rnd%0d", n), memc, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), wf, wm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
